// File: rtl/nx_stream_pkg.sv
// nx_stream_pkg: shared types and constants for the nx_stream blocks.
//   arb_state_e : arbiter FSM state (IDLE = arbitrating, LOCKED = grant held)
//   COUNT_W     : width of the per-input beat counters
//   sat_inc     : saturating increment for COUNT_W-bit counters
package nx_stream_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned COUNT_W = 16;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nx_rr_select.sv
// nx_rr_select: combinational rotating-priority picker.
// Finds the first set bit of req_i, searching upward from ptr_i with wrap.
// Ports:
//   req_i   [N]      request vector
//   ptr_i   [IDX_W]  highest-priority position (must be < N)
//   grant_o [N]      one-hot grant (all zero when no request)
//   idx_o   [IDX_W]  index of the granted bit (0 when no request)
//   any_o            at least one request present
module nx_rr_select #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/nx_stream_arbiter.sv
// nx_stream_arbiter: round-robin, message-locking stream arbiter.
// Optional feature macro: NX_STREAM_ARB_COUNT_EN (adds beat_count_o).
// Handshake: a beat transfers on a port when its valid and ready are both
// high on a rising clk_i edge; ready never depends on that port's own valid
// except through grant selection in IDLE.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   inbound_data_i       [INPUTS][STREAM_WIDTH] per-input beat data
//   inbound_valid_i      [INPUTS] per-input valid
//   inbound_last_i       [INPUTS] per-input last-beat flag
//   inbound_ready_o      [INPUTS] per-input ready (only the granted one)
//   outbound_data_o      selected beat data
//   outbound_valid_o     selected beat valid
//   outbound_last_o      selected beat last
//   outbound_ready_i     downstream ready
//   beat_count_o         [INPUTS][16] saturating beat counts (macro only)
//   idle_o               IDLE and no inbound valid
module nx_stream_arbiter
  import nx_stream_pkg::*;
#(
  parameter int STREAM_WIDTH = 32,
  parameter int INPUTS       = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [INPUTS-1:0][STREAM_WIDTH-1:0]  inbound_data_i,
  input  logic [INPUTS-1:0]                    inbound_valid_i,
  input  logic [INPUTS-1:0]                    inbound_last_i,
  output logic [INPUTS-1:0]                    inbound_ready_o,
  output logic [STREAM_WIDTH-1:0]              outbound_data_o,
  output logic                                 outbound_valid_o,
  output logic                                 outbound_last_o,
  input  logic                                 outbound_ready_i,
`ifdef NX_STREAM_ARB_COUNT_EN
  output logic [INPUTS-1:0][COUNT_W-1:0]       beat_count_o,
`endif
  output logic                                 idle_o
);

  localparam int PTR_W = $clog2(INPUTS);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] lock_q, lock_d;

  logic [INPUTS-1:0] sel_grant;
  logic [PTR_W-1:0]  sel_idx;
  logic              sel_any;

  logic              grant_act;
  logic [PTR_W-1:0]  grant_idx;
  logic [INPUTS-1:0] grant_vec;
  logic              out_valid;
  logic              out_last;
  logic              xfer;
  logic              xfer_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(INPUTS - 1)) ? '0 : p + 1'b1;
  endfunction

  nx_rr_select #(.N(INPUTS), .IDX_W(PTR_W)) u_rr_select (
    .req_i   (inbound_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (sel_grant),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_act) begin
          if (xfer_last) begin
            ptr_d = ptr_inc(grant_idx);
          end else begin
            state_d = ARB_LOCKED;
            lock_d  = grant_idx;
          end
        end
      end
      ARB_LOCKED: begin
        if (xfer_last) begin
          state_d = ARB_IDLE;
          ptr_d   = ptr_inc(lock_q);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output logic. Outputs are gated by rst_ni so they go quiet the moment
  // reset asserts, without waiting for the registers to be observed.
  always_comb begin
    grant_act = 1'b0;
    grant_idx = sel_idx;
    grant_vec = '0;
    if (rst_ni) begin
      if (state_q == ARB_LOCKED) begin
        // Grant is held on the locked input even if its valid drops.
        grant_act = 1'b1;
        grant_idx = lock_q;
        grant_vec = INPUTS'(1) << lock_q;
      end else begin
        grant_act = sel_any;
        grant_idx = sel_idx;
        grant_vec = sel_grant;
      end
    end
    out_valid        = grant_act & inbound_valid_i[grant_idx];
    out_last         = grant_act & inbound_last_i[grant_idx];
    xfer             = out_valid & outbound_ready_i;
    xfer_last        = xfer & out_last;
    outbound_data_o  = inbound_data_i[grant_idx];
    outbound_valid_o = out_valid;
    outbound_last_o  = out_last;
    inbound_ready_o  = grant_vec & {INPUTS{outbound_ready_i}};
    idle_o           = !rst_ni || ((state_q == ARB_IDLE) && !(|inbound_valid_i));
  end

`ifdef NX_STREAM_ARB_COUNT_EN
  logic [INPUTS-1:0][COUNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < INPUTS; i++) begin
        if (xfer && (grant_idx == PTR_W'(i))) cnt_q[i] <= sat_inc(cnt_q[i]);
      end
    end
  end

  assign beat_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// tb_nx_stream_arbiter: directed self-checking bench for nx_stream_arbiter
// (INPUTS = 4, STREAM_WIDTH = 32). Inputs change on the falling edge and
// outputs are checked 1 ns later; state commits on the rising edge.
module tb_nx_stream_arbiter;
  import nx_stream_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  logic                clk;
  logic                rst_n;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]        in_valid;
  logic [N-1:0]        in_last;
  logic [N-1:0]        in_ready;
  logic [W-1:0]        out_data;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;
  logic                idle;
`ifdef NX_STREAM_ARB_COUNT_EN
  logic [N-1:0][COUNT_W-1:0] beat_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  nx_stream_arbiter #(.STREAM_WIDTH(W), .INPUTS(N)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .inbound_data_i   (in_data),
    .inbound_valid_i  (in_valid),
    .inbound_last_i   (in_last),
    .inbound_ready_o  (in_ready),
    .outbound_data_o  (out_data),
    .outbound_valid_o (out_valid),
    .outbound_last_o  (out_last),
    .outbound_ready_i (out_ready),
`ifdef NX_STREAM_ARB_COUNT_EN
    .beat_count_o     (beat_count),
`endif
    .idle_o           (idle)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] d(input int i, input int b);
    return 32'hC0DE_0000 | W'(i << 8) | W'(b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) in_data[i] = d(i, 0);

    // Reset state, with requests present to prove they are masked
    repeat (2) @(negedge clk);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
    chk("rst_ptr", 32'(dut.ptr_q), 32'd0);
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b1;
    #1;
    chk("post_rst_idle", 32'(idle), 32'd1);

    // Inputs 0 and 2 single-beat: grant 0 then 2, pointer ends at 3
    @(negedge clk);
    in_valid = 4'b0101; in_last = 4'b0101;
    #1;
    chk("t1_ready0", 32'(in_ready), 32'b0001);
    chk("t1_data0", out_data, d(0, 0));
    chk("t1_last0", 32'(out_last), 32'd1);
    @(negedge clk);
    in_valid = 4'b0100;
    #1;
    chk("t1_ready2", 32'(in_ready), 32'b0100);
    chk("t1_data2", out_data, d(2, 0));
    @(negedge clk);
    in_valid = '0; in_last = '0;
    #1;
    chk("t1_ptr", 32'(dut.ptr_q), 32'd3);
    chk("t1_state", 32'(dut.state_q), 32'(ARB_IDLE));
    chk("t1_out_valid", 32'(out_valid), 32'd0);

    // Input 1 three-beat message; input 3 must wait for its last beat
    @(negedge clk);
    in_valid = 4'b0010; in_last = 4'b0000;
    #1;
    chk("t2_b0_ready", 32'(in_ready), 32'b0010);
    chk("t2_b0_data", out_data, d(1, 0));
    chk("t2_b0_last", 32'(out_last), 32'd0);
    @(negedge clk);
    in_valid = 4'b1010; in_last = 4'b1000; in_data[1] = d(1, 1);
    #1;
    chk("t2_b1_state", 32'(dut.state_q), 32'(ARB_LOCKED));
    chk("t2_b1_ready", 32'(in_ready), 32'b0010);
    chk("t2_b1_data", out_data, d(1, 1));
    @(negedge clk);
    in_last = 4'b1010; in_data[1] = d(1, 2);
    #1;
    chk("t2_b2_ready", 32'(in_ready), 32'b0010);
    chk("t2_b2_last", 32'(out_last), 32'd1);
    @(negedge clk);
    in_valid = 4'b1000; in_last = 4'b1000; in_data[1] = d(1, 0);
    #1;
    chk("t2_in3_ready", 32'(in_ready), 32'b1000);
    chk("t2_in3_data", out_data, d(3, 0));
    chk("t2_ptr", 32'(dut.ptr_q), 32'd2);
    @(negedge clk);
    in_valid = '0; in_last = '0;
    #1;
    chk("t2_ptr_end", 32'(dut.ptr_q), 32'd0);

    // Input 2 stalled for 4 cycles; input 0 arrives mid-stall and is ignored
    @(negedge clk);
    in_valid = 4'b0100; in_last = 4'b0100; out_ready = 1'b0;
    #1;
    chk("t3_c0_ready", 32'(in_ready), 32'h0);
    chk("t3_c0_valid", 32'(out_valid), 32'd1);
    chk("t3_c0_data", out_data, d(2, 0));
    @(negedge clk);
    #1;
    chk("t3_c1_state", 32'(dut.state_q), 32'(ARB_LOCKED));
    chk("t3_c1_data", out_data, d(2, 0));
    @(negedge clk);
    in_valid = 4'b0101; in_last = 4'b0101;
    #1;
    chk("t3_c2_data", out_data, d(2, 0));
    chk("t3_c2_ready", 32'(in_ready), 32'h0);
    chk("t3_c2_state", 32'(dut.state_q), 32'(ARB_LOCKED));
    @(negedge clk);
    #1;
    chk("t3_c3_data", out_data, d(2, 0));
    chk("t3_c3_state", 32'(dut.state_q), 32'(ARB_LOCKED));
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("t3_release_ready", 32'(in_ready), 32'b0100);
    @(negedge clk);
    in_valid = 4'b0001; in_last = 4'b0001;
    #1;
    chk("t3_in0_ready", 32'(in_ready), 32'b0001);
    chk("t3_in0_data", out_data, d(0, 0));
    chk("t3_ptr", 32'(dut.ptr_q), 32'd3);
    @(negedge clk);
    in_valid = '0; in_last = '0;
    #1;
    chk("t3_ptr_end", 32'(dut.ptr_q), 32'd1);

    // Reset pulse, then all four continuously valid: 0,1,2,3,0
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t4_ptr_start", 32'(dut.ptr_q), 32'd0);
    in_valid = 4'b1111; in_last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4_grant%0d", k), 32'(in_ready), 32'(1 << (k % 4)));
      chk($sformatf("t4_data%0d", k), out_data, d(k % 4, 0));
      @(negedge clk);
    end
    in_valid = '0; in_last = '0;
    #1;
    chk("t4_ptr_end", 32'(dut.ptr_q), 32'd1);

    // Reset during beat 2 of input 1's message; input 0 wins afterwards
    @(negedge clk);
    in_valid = 4'b0010; in_last = 4'b0000;
    #1;
    chk("t5_b0_ready", 32'(in_ready), 32'b0010);
    @(negedge clk);
    in_valid = 4'b0011; in_last = 4'b0001; in_data[1] = d(1, 1);
    #1;
    chk("t5_locked", 32'(dut.state_q), 32'(ARB_LOCKED));
    chk("t5_b1_ready", 32'(in_ready), 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'h0);
    chk("t5_rst_idle", 32'(idle), 32'd1);
    chk("t5_rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_post_ready", 32'(in_ready), 32'b0001);
    chk("t5_post_data", out_data, d(0, 0));
    @(negedge clk);
    in_valid = '0; in_last = '0; in_data[1] = d(1, 0);

`ifdef NX_STREAM_ARB_COUNT_EN
    // Saturation: 70000 beats on input 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cnt_reset0", 32'(beat_count[0]), 32'h0);
    in_valid = 4'b0001; in_last = 4'b0001; out_ready = 1'b1;
    repeat (70000) @(negedge clk);
    in_valid = '0; in_last = '0;
    #1;
    chk("cnt_sat0", 32'(beat_count[0]), 32'hFFFF);
    chk("cnt_1", 32'(beat_count[1]), 32'h0);
    chk("cnt_2", 32'(beat_count[2]), 32'h0);
    chk("cnt_3", 32'(beat_count[3]), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nx_stream_arbiter.md
NX_STREAM_ARBITER -- requirements
Module: nx_stream_arbiter

Interface
REQ-001 SHALL have parameter STREAM_WIDTH, default 32, width of each message beat.
REQ-002 SHALL have parameter INPUTS, default 4, number of inbound streams; legal range 2..16.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port inbound_data_i  input  INPUTS x STREAM_WIDTH  per-input beat data.
REQ-006 SHALL have port inbound_valid_i  input  INPUTS  per-input beat valid.
REQ-007 SHALL have port inbound_last_i  input  INPUTS  per-input final-beat-of-message flag.
REQ-008 SHALL have port inbound_ready_o  output  INPUTS  per-input ready.
REQ-009 SHALL have port outbound_data_o  output  STREAM_WIDTH  selected beat data.
REQ-010 SHALL have port outbound_valid_o  output  1  selected beat valid.
REQ-011 SHALL have port outbound_last_o  output  1  selected beat last flag.
REQ-012 SHALL have port outbound_ready_i  input  1  downstream ready (typically an nx_stream_skid inbound).
REQ-013 SHALL have port idle_o  output  1  high when state is IDLE and no inbound_valid_i bit is set.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (arbitrating) and LOCKED (grant held on one input).
REQ-015 SHALL hold a round-robin pointer of $clog2(INPUTS) bits; wraps from INPUTS-1 to 0.
REQ-016 In IDLE, grant SHALL go to the first input with valid high, searching upward from pointer with wrap.
REQ-017 Data path SHALL be zero latency: outbound_data/valid/last combinationally follow the granted input; valid low when no grant.
REQ-018 inbound_ready_o[i] SHALL equal outbound_ready_i AND (grant == i); all non-granted readies low.
REQ-019 A transfer SHALL occur when outbound_valid_o and outbound_ready_i are both high.
REQ-020 IDLE -> LOCKED on granted input g if no transfer-with-last occurs that cycle (stalled beat or non-last beat).
REQ-021 IDLE, transfer with last: SHALL stay IDLE; pointer <= g+1 (wrapped).
REQ-022 In LOCKED, only the locked input SHALL be considered; other valids ignored; grant stable even if locked valid drops.
REQ-023 LOCKED -> IDLE on transfer with last; pointer <= locked+1 (wrapped).
REQ-024 Simultaneous valids in IDLE SHALL resolve solely by pointer order; no starvation: each requester granted within INPUTS messages.

Reset
REQ-025 While rst_ni low: state IDLE, pointer 0, outbound_valid_o 0, all inbound_ready_o 0, idle_o 1, counters 0.
REQ-026 Reset asserted mid-message SHALL abandon the lock immediately; first grant after release follows REQ-016 from pointer 0.

Configuration
REQ-027 With NX_STREAM_ARB_COUNT_EN defined, SHALL add output beat_count_o (INPUTS x 16): per-input transferred-beat count, saturating at 0xFFFF.
REQ-028 Without NX_STREAM_ARB_COUNT_EN, the port and counters SHALL be absent; all other behaviour identical.

Structure
REQ-029 FSM state typedef and count width constant (16) SHALL live in shared package nx_stream_pkg.
REQ-030 Rotating-priority pick SHALL be sub-module nx_rr_select (request vector + pointer in, one-hot grant + index out, combinational).

Verification
REQ-031 Inputs 0,2 valid single-beat last, ready=1, pointer 0 -> cycle0 grant 0, cycle1 grant 2, pointer ends 3.
REQ-032 Input 1 sends 3-beat message, input 3 valid throughout -> input 3 ready held 0 until input 1 last beat transfers.
REQ-033 Input 2 valid, outbound_ready_i=0 for 4 cycles, input 0 raises valid in cycle 2 -> data stays input 2's, state LOCKED.
REQ-034 All 4 inputs continuously valid single-beat -> grant sequence 0,1,2,3,0 (wrap verified).
REQ-035 rst_ni low during beat 2 of input 1 message -> outputs/readies 0 that cycle; after release input 0 granted first.
REQ-036 With NX_STREAM_ARB_COUNT_EN, 70000 beats on input 0 -> beat_count_o[0] = 0xFFFF, others 0.
